// File: rtl/srb.sv
// rtl/srb.sv - single-stage shift/reload register bit for reconfigurable delay lines
module srb #(
  parameter int unsigned            WIDTH   = 1,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             toggle,
  output logic [WIDTH-1:0] out1
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  // toggle picks the broadcast shortcut so this stage restarts the delay line
  always_comb begin
    r_d = r_q;
    if (start) begin
      r_d = toggle ? in2 : in1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= r_d;
    end
  end

  assign out1 = r_q;

endmodule

// File: tb/tb_srb.sv
// tb/tb_srb.sv - directed self-checking bench for srb (single, wide and 12-stage chain)
module tb_srb;

  localparam int N = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // single 1-bit stage
  logic rst, start, in1, in2, toggle;
  logic out1;

  // wide stage with non-zero reset value
  logic [7:0] in1w, in2w, out1w;

  // 12-stage chain
  logic         c_rst, c_start, c_head, c_in2;
  logic [N-1:0] c_tog;
  logic [N-1:0] c_out;

  srb dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .toggle(toggle), .out1(out1)
  );

  srb #(.WIDTH(8), .RST_VAL(8'hA5)) dut_w (
    .clk(clk), .rst(rst), .start(start), .in1(in1w), .in2(in2w),
    .toggle(toggle), .out1(out1w)
  );

  for (genvar k = 0; k < N; k++) begin : g_chain
    srb u_stage (
      .clk(clk), .rst(c_rst), .start(c_start),
      .in1((k == 0) ? c_head : c_out[(k == 0) ? 0 : k-1]),
      .in2(c_in2), .toggle(c_tog[k]), .out1(c_out[k])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in1 = 1'b1; in2 = 1'b1; toggle = 1'b0;
    in1w = 8'hFF; in2w = 8'hFF;
    c_rst = 1'b1; c_start = 1'b1; c_head = 1'b1; c_in2 = 1'b1; c_tog = '1;
    step();
    checks++;
    if (out1 !== 1'b0) begin
      failures++; $display("FAIL reset_first_edge out1=%b expected=0", out1);
    end
    checks++;
    if (out1w !== 8'hA5) begin
      failures++; $display("FAIL reset_rst_val out1w=%h expected=a5", out1w);
    end
    checks++;
    if (c_out !== 12'h000) begin
      failures++; $display("FAIL reset_chain c_out=%b expected=0", c_out);
    end
    for (int i = 0; i < 3; i++) begin
      toggle = i[0];
      step();
      checks++;
      if (out1 !== 1'b0) begin
        failures++; $display("FAIL reset_hold%0d out1=%b expected=0", i, out1);
      end
    end
    // release reset with start low: value must stay at reset value
    rst = 1'b0; start = 1'b0;
    step();
    checks++;
    if (out1 !== 1'b0 || out1w !== 8'hA5) begin
      failures++; $display("FAIL reset_release_nostart out1=%b out1w=%h expected=0/a5", out1, out1w);
    end
  endtask

  task automatic test_shift();
    start = 1'b1; toggle = 1'b0; in1 = 1'b1; in2 = 1'b0;
    in1w = 8'h3C; in2w = 8'h00;
    step();
    checks++;
    if (out1 !== 1'b1) begin
      failures++; $display("FAIL shift_pulse out1=%b expected=1", out1);
    end
    checks++;
    if (out1w !== 8'h3C) begin
      failures++; $display("FAIL shift_wide out1w=%h expected=3c", out1w);
    end
    in1 = 1'b0;
    step();
    checks++;
    if (out1 !== 1'b0) begin
      failures++; $display("FAIL shift_after out1=%b expected=0", out1);
    end
  endtask

  task automatic test_shortcut();
    toggle = 1'b1; in1 = 1'b0; in2 = 1'b1; in1w = 8'h11; in2w = 8'h5A;
    step();
    checks++;
    if (out1 !== 1'b1) begin
      failures++; $display("FAIL shortcut_in2 out1=%b expected=1", out1);
    end
    checks++;
    if (out1w !== 8'h5A) begin
      failures++; $display("FAIL shortcut_wide out1w=%h expected=5a", out1w);
    end
    in1 = 1'b1; in2 = 1'b0;
    step();
    checks++;
    if (out1 !== 1'b0) begin
      failures++; $display("FAIL shortcut_ignore_in1 out1=%b expected=0", out1);
    end
  endtask

  task automatic test_hold();
    start = 1'b1; toggle = 1'b0; in1 = 1'b1; in2 = 1'b0;
    step();
    checks++;
    if (out1 !== 1'b1) begin
      failures++; $display("FAIL hold_load out1=%b expected=1", out1);
    end
    start = 1'b0; in1 = 1'b0; in2 = 1'b0; in1w = 8'h00; in2w = 8'h00;
    for (int i = 0; i < 5; i++) begin
      toggle = i[0];
      step();
      checks++;
      if (out1 !== 1'b1) begin
        failures++; $display("FAIL hold_cycle%0d out1=%b expected=1", i, out1);
      end
    end
    checks++;
    if (out1w !== 8'h11) begin
      failures++; $display("FAIL hold_wide out1w=%h expected=11", out1w);
    end
    start = 1'b1; toggle = 1'b0;
    step();
    checks++;
    if (out1 !== 1'b0) begin
      failures++; $display("FAIL hold_resume out1=%b expected=0", out1);
    end
  endtask

  task automatic test_chain_straight();
    logic [N-1:0] exp;
    c_rst = 1'b0; c_start = 1'b1; c_tog = '0; c_head = 1'b0; c_in2 = 1'b0;
    step();
    c_head = 1'b1; c_in2 = 1'b1;
    for (int c = 1; c <= N + 1; c++) begin
      step();
      c_head = 1'b0; c_in2 = 1'b0;
      exp = '0;
      if (c <= N) exp[c-1] = 1'b1;
      checks++;
      if (c_out !== exp) begin
        failures++; $display("FAIL chain_straight_c%0d c_out=%b expected=%b", c, c_out, exp);
      end
    end
  endtask

  task automatic test_chain_toggle9();
    logic [N-1:0] exp_tab [1:12];
    exp_tab[1]  = 12'b0010_0000_0001;
    exp_tab[2]  = 12'b0100_0000_0010;
    exp_tab[3]  = 12'b1000_0000_0100;
    exp_tab[4]  = 12'b0000_0000_1000;
    exp_tab[5]  = 12'b0000_0001_0000;
    exp_tab[6]  = 12'b0000_0010_0000;
    exp_tab[7]  = 12'b0000_0100_0000;
    exp_tab[8]  = 12'b0000_1000_0000;
    exp_tab[9]  = 12'b0001_0000_0000;
    exp_tab[10] = 12'b0000_0000_0000;
    exp_tab[11] = 12'b0000_0000_0000;
    exp_tab[12] = 12'b0000_0000_0000;
    c_tog = 12'b0010_0000_0000; c_head = 1'b1; c_in2 = 1'b1;
    for (int c = 1; c <= N; c++) begin
      step();
      c_head = 1'b0; c_in2 = 1'b0;
      checks++;
      if (c_out !== exp_tab[c]) begin
        failures++; $display("FAIL chain_tog9_c%0d c_out=%b expected=%b", c, c_out, exp_tab[c]);
      end
    end
    // reset in mid-propagation clears every stage despite live data
    c_tog = '0; c_head = 1'b1;
    step();
    c_head = 1'b0;
    step();
    step();
    checks++;
    if (c_out !== 12'b0000_0000_0100) begin
      failures++; $display("FAIL chain_midprop c_out=%b expected=000000000100", c_out);
    end
    c_rst = 1'b1; c_head = 1'b1; c_in2 = 1'b1; c_tog = 12'b0000_0000_0001;
    step();
    checks++;
    if (c_out !== 12'h000) begin
      failures++; $display("FAIL chain_mid_reset c_out=%b expected=0", c_out);
    end
    c_rst = 1'b0; c_head = 1'b0; c_in2 = 1'b0; c_tog = '0;
    step();
    checks++;
    if (c_out !== 12'h000) begin
      failures++; $display("FAIL chain_post_reset c_out=%b expected=0", c_out);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in1 = 1'b0; in2 = 1'b0; toggle = 1'b0;
    in1w = '0; in2w = '0;
    c_rst = 1'b1; c_start = 1'b0; c_head = 1'b0; c_in2 = 1'b0; c_tog = '0;
    #2;
    test_reset();
    test_shift();
    test_shortcut();
    test_hold();
    test_chain_straight();
    test_chain_toggle9();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
